painterengine_gpu_dvi_capture: RTL and testbench

//  Receive end of the GPU DVI video path. Samples an hs/vs/de/rgb stream and detects frame boundaries.

---
 rtl/painterengine_gpu_dvi_capture_pkg.sv | 47 ++++
 rtl/painterengine_gpu_dvi_capture_fifo.sv | 56 +++++
 rtl/painterengine_gpu_dvi_capture.sv | 162 ++++++++++++++++
 tb/tb_painterengine_gpu_dvi_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_dvi_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : painterengine_gpu_dvi_capture_pkg
// Brief    : Shared pixel-packing codes, capture FSM states and helpers for the
//            DVI capture block.
// Revision : 1.0 - initial release
// ============================================================================
package painterengine_gpu_dvi_capture_pkg;

    // Packing mode codes (mirror the transmitter's unpack modes)
    localparam logic [2:0] DVI_RGB_MODE_ARGB = 3'd0;
    localparam logic [2:0] DVI_RGB_MODE_RGBA = 3'd1;
    localparam logic [2:0] DVI_RGB_MODE_ABGR = 3'd2;
    localparam logic [2:0] DVI_RGB_MODE_BGRA = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_t;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Inverse of the transmitter unpack; alpha byte is always opaque
    function automatic logic [31:0] pack_pixel(input logic [2:0] mode, input logic [23:0] rgb);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        case (mode)
            DVI_RGB_MODE_ARGB: return {r, g, b, 8'hFF};
            DVI_RGB_MODE_RGBA: return {g, r, b, 8'hFF};
            DVI_RGB_MODE_ABGR,
            DVI_RGB_MODE_BGRA: return {b, g, r, 8'hFF};
            default:           return 32'h0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/painterengine_gpu_dvi_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module   : painterengine_gpu_dvi_capture_fifo
// Brief    : Single-clock first-word-fall-through FIFO. A write to a full FIFO
//            is accepted only when a read happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module painterengine_gpu_dvi_capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer MSB distinguishes full from empty
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; on full+read the freed head slot becomes the new tail
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update, wrapping naturally modulo the depth
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/painterengine_gpu_dvi_capture.sv
`default_nettype none
// ============================================================================
// Module   : painterengine_gpu_dvi_capture
// Brief    : DVI receive path. Registers the video stream, captures one frame
//            per start request into a packed-pixel FIFO and measures the
//            active width/height of the incoming timing.
// Revision : 1.0 - initial release
// ============================================================================
module painterengine_gpu_dvi_capture
    import painterengine_gpu_dvi_capture_pkg::*;
#(
    parameter int PARAM_DATA_WIDTH = 32,
    parameter int PARAM_FIFO_DEPTH = 16
) (
    input  logic                        i_wire_pixel_clock,
    input  logic                        i_wire_resetn,
    input  logic                        i_wire_start,
    input  logic                        i_wire_hs,
    input  logic                        i_wire_vs,
    input  logic                        i_wire_vs_pol,
    input  logic                        i_wire_de,
    input  logic [23:0]                 i_wire_rgb,
    input  logic [2:0]                  i_wire_rgba_mode,
    input  logic [15:0]                 i_wire_clip_width,
    input  logic [15:0]                 i_wire_clip_height,
    output logic [PARAM_DATA_WIDTH-1:0] o_wire_rgba,
    output logic                        o_wire_valid,
    input  logic                        i_wire_ready,
    output logic [15:0]                 o_wire_width,
    output logic [15:0]                 o_wire_height,
    output logic                        o_wire_busy,
    output logic                        o_wire_done,
    output logic                        o_wire_overflow
);
    cap_state_t                  state_q;
    cap_state_t                  state_d;
    logic                        vs_q;
    logic                        vs_prev;
    logic                        de_q;
    logic                        de_prev;
    logic [23:0]                 rgb_q;
    logic [15:0]                 x_cnt;
    logic [15:0]                 y_cnt;
    logic [15:0]                 width;
    logic [15:0]                 height;
    logic                        overflow;
    logic                        vs_lead;
    logic                        de_fall;
    logic                        start_ok;
    logic                        pix_wr;
    logic                        fifo_rd;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [PARAM_DATA_WIDTH-1:0] pix_word;
    logic                        hs_unused;

    // hs carries no timing information for capture
    assign hs_unused = i_wire_hs;

    assign vs_lead  = (vs_q == i_wire_vs_pol) && (vs_prev != i_wire_vs_pol);
    assign de_fall  = de_prev && !de_q;
    assign start_ok = i_wire_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // The cycle carrying the closing vs edge is never written
    assign pix_wr   = (state_q == ST_CAPTURE) && !vs_lead && de_q &&
                      (x_cnt < i_wire_clip_width) && (y_cnt < i_wire_clip_height);
    assign pix_word = pack_pixel(i_wire_rgba_mode, rgb_q);
    assign fifo_rd  = o_wire_valid && i_wire_ready;

    // Input stage: one register on the video stream plus edge history
    always_ff @(posedge i_wire_pixel_clock) begin
        if (!i_wire_resetn) begin
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
            de_q    <= 1'b0;
            de_prev <= 1'b0;
            rgb_q   <= '0;
        end else begin
            vs_q    <= i_wire_vs;
            vs_prev <= vs_q;
            de_q    <= i_wire_de;
            de_prev <= de_q;
            rgb_q   <= i_wire_rgb;
        end
    end

    // FSM state register
    always_ff @(posedge i_wire_pixel_clock) begin
        if (!i_wire_resetn) state_q <= ST_IDLE;
        else                state_q <= state_d;
    end

    // FSM next-state: arm on start, frame on vs edges, finish once drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_ok)   state_d = ST_ARMED;
            ST_ARMED:   if (vs_lead)    state_d = ST_CAPTURE;
            ST_CAPTURE: if (vs_lead)    state_d = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty) state_d = ST_DONE;
            ST_DONE:    if (start_ok)   state_d = ST_ARMED;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Position counters, geometry measurement and sticky overflow
    always_ff @(posedge i_wire_pixel_clock) begin
        if (!i_wire_resetn) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            width    <= '0;
            height   <= '0;
            overflow <= 1'b0;
        end else begin
            if (start_ok) begin
                width    <= '0;
                height   <= '0;
                overflow <= 1'b0;
            end
            if ((state_q == ST_ARMED) && vs_lead) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end
            if (state_q == ST_CAPTURE) begin
                if (vs_lead) begin
                    height <= y_cnt;
                end else if (de_q) begin
                    x_cnt <= sat_inc(x_cnt);
                end else if (de_fall) begin
                    width <= x_cnt;
                    y_cnt <= sat_inc(y_cnt);
                    x_cnt <= '0;
                end
            end
            if (pix_wr && fifo_full && !fifo_rd) begin
                overflow <= 1'b1;
            end
        end
    end

    painterengine_gpu_dvi_capture_fifo #(
        .WIDTH (PARAM_DATA_WIDTH),
        .DEPTH (PARAM_FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_wire_pixel_clock),
        .resetn  (i_wire_resetn),
        .wr_en   (pix_wr),
        .wr_data (pix_word),
        .rd_en   (fifo_rd),
        .rd_data (o_wire_rgba),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_wire_valid    = !fifo_empty;
    assign o_wire_width    = width;
    assign o_wire_height   = height;
    assign o_wire_busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign o_wire_done     = (state_q == ST_DONE);
    assign o_wire_overflow = overflow;

endmodule
`default_nettype wire

// File: tb/tb_painterengine_gpu_dvi_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_painterengine_gpu_dvi_capture
// Brief    : Self-checking bench: drives synthetic DVI frames and compares the
//            captured word stream and status against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_painterengine_gpu_dvi_capture;

    logic        clk = 1'b0;
    logic        resetn, start, hs, vs, vs_pol, de, ready;
    logic [23:0] rgb;
    logic [2:0]  mode;
    logic [15:0] clip_w, clip_h;
    logic [31:0] rgba;
    logic        valid, busy, done, overflow;
    logic [15:0] width, height;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          hbl      = 8;
    bit          ready_rand = 1'b0;
    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    painterengine_gpu_dvi_capture dut (
        .i_wire_pixel_clock (clk),
        .i_wire_resetn      (resetn),
        .i_wire_start       (start),
        .i_wire_hs          (hs),
        .i_wire_vs          (vs),
        .i_wire_vs_pol      (vs_pol),
        .i_wire_de          (de),
        .i_wire_rgb         (rgb),
        .i_wire_rgba_mode   (mode),
        .i_wire_clip_width  (clip_w),
        .i_wire_clip_height (clip_h),
        .o_wire_rgba        (rgba),
        .o_wire_valid       (valid),
        .i_wire_ready       (ready),
        .o_wire_width       (width),
        .o_wire_height      (height),
        .o_wire_busy        (busy),
        .o_wire_done        (done),
        .o_wire_overflow    (overflow)
    );

    // Consumer: record every word handed over (valid & ready at the next edge)
    always @(negedge clk) begin
        if (resetn === 1'b1 && valid === 1'b1 && ready === 1'b1) got.push_back(rgba);
    end

    // Reference packing table
    function automatic logic [31:0] ref_pack(input logic [2:0] m, input logic [23:0] p);
        logic [7:0] r, g, b;
        r = p[23:16]; g = p[15:8]; b = p[7:0];
        case (m)
            3'd0:       return {r, g, b, 8'hFF};
            3'd1:       return {g, r, b, 8'hFF};
            3'd2, 3'd3: return {b, g, r, 8'hFF};
            default:    return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        hs = 1'($urandom_range(0, 1));
        if (ready_rand) ready = cyc[0] | 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic vsync_pulse();
        vs = vs_pol;  repeat (3) tick();
        vs = ~vs_pol; repeat (4) tick();
    endtask

    // Raster of w x h active pixels; optionally predicts the kept words
    task automatic send_lines(input int w, input int h, input bit rnd, input bit model,
                              input int tag, input int start_line);
        for (int y = 0; y < h; y++) begin
            if (y == start_line) pulse_start();
            for (int x = 0; x < w; x++) begin
                logic [23:0] p;
                p = rnd ? 24'($urandom) : {8'(x), 8'(y) ^ 8'(tag), 8'h5A};
                de = 1'b1; rgb = p;
                if (model && x < int'(clip_w) && y < int'(clip_h)) exp_q.push_back(ref_pack(mode, p));
                tick();
            end
            de = 1'b0; rgb = 24'($urandom);
            repeat (hbl) tick();
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin tick(); n++; end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic capture(input int w, input int h, input bit rnd, input int start_line);
        pulse_start();
        vsync_pulse();
        send_lines(w, h, rnd, 1'b1, 0, start_line);
        vsync_pulse();
        wait_done("capture_done");
    endtask

    task automatic check_words(input string tag);
        int nmis = 0;
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) nmis++;
        chk({tag, "_data_mismatches"}, 32'(nmis), 32'd0);
        got.delete(); exp_q.delete();
    endtask

    initial begin
        logic [31:0] mode_tbl [5];
        mode_tbl = '{32'h112233FF, 32'h221133FF, 32'h332211FF, 32'h332211FF, 32'h00000000};
        resetn = 1'b0; start = 1'b0; hs = 1'b0; vs = 1'b0; vs_pol = 1'b1; de = 1'b0;
        rgb = '0; mode = 3'd0; clip_w = 16'd128; clip_h = 16'd64; ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(valid), 0);   chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);     chk("rst_ovf", 32'(overflow), 0);
        chk("rst_width", 32'(width), 0);   chk("rst_height", 32'(height), 0);
        chk("rst_rgba", rgba, 0);
        resetn = 1'b1; tick();

        // Full 128x64 ARGB frame
        capture(128, 64, 1'b0, -1);
        chk("t1_word_3_2", got[2*128+3], 32'h03025AFF);
        check_words("t1");
        chk("t1_width", 32'(width), 128); chk("t1_height", 32'(height), 64);
        chk("t1_ovf", 32'(overflow), 0);

        // Same frame clipped to 100x50
        clip_w = 16'd100; clip_h = 16'd50;
        capture(128, 64, 1'b0, -1);
        chk("t2_last_word", got[got.size()-1], 32'h63315AFF);
        check_words("t2");
        chk("t2_width", 32'(width), 128); chk("t2_height", 32'(height), 64);

        // Stalled consumer: FIFO fills with the first 16 pixels, rest dropped
        clip_w = 16'd128; clip_h = 16'd64; ready = 1'b0;
        pulse_start(); vsync_pulse();
        send_lines(20, 4, 1'b0, 1'b0, 0, -1);
        vsync_pulse(); repeat (4) tick();
        for (int i = 0; i < 16; i++) exp_q.push_back({8'(i), 8'h00, 8'h5A, 8'hFF});
        chk("t3_valid", 32'(valid), 1);  chk("t3_ovf", 32'(overflow), 1);
        chk("t3_busy", 32'(busy), 1);    chk("t3_done", 32'(done), 0);
        chk("t3_head", rgba, 32'h00005AFF);
        ready = 1'b1;
        wait_done("t3_done_after_drain");
        check_words("t3");
        chk("t3_ovf_sticky", 32'(overflow), 1);
        chk("t3_width", 32'(width), 20); chk("t3_height", 32'(height), 4);

        // Packing modes and one-cycle write latency
        hbl = 4;
        for (int m = 0; m < 5; m++) begin
            mode = 3'(m); ready = 1'b0;
            pulse_start();
            chk("t4_start_clears_ovf", 32'(overflow), 0);
            chk("t4_start_clears_width", 32'(width), 0);
            vsync_pulse();
            de = 1'b1; rgb = 24'h112233; tick();
            chk("t4_valid_before_write", 32'(valid), 0);
            de = 1'b0; tick();
            chk("t4_valid_after_write", 32'(valid), 1);
            chk("t4_mode_word", rgba, mode_tbl[m]);
            ready = 1'b1; repeat (hbl) tick();
            vsync_pulse();
            wait_done("t4_done");
            chk("t4_width", 32'(width), 1);
            got.delete();
        end

        // Reset in the middle of a line
        hbl = 8; mode = 3'd0; ready = 1'b0;
        pulse_start(); vsync_pulse();
        repeat (10) begin de = 1'b1; rgb = 24'($urandom); tick(); end
        de = 1'b0; repeat (hbl) tick();
        chk("t5_width_before_reset", 32'(width), 10);
        repeat (5) begin de = 1'b1; rgb = 24'($urandom); tick(); end
        chk("t5_valid_before_reset", 32'(valid), 1);
        resetn = 1'b0; de = 1'b0; tick();
        chk("t5_valid", 32'(valid), 0); chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);   chk("t5_width", 32'(width), 0);
        resetn = 1'b1; ready = 1'b1; tick();

        // Randomized frames; start pulsed mid-capture must be ignored
        ready_rand = 1'b1; hbl = 20;
        for (int it = 0; it < 4; it++) begin
            int w, h;
            mode   = 3'($urandom_range(0, 7));
            w      = $urandom_range(4, 20);
            h      = $urandom_range(2, 8);
            clip_w = 16'($urandom_range(0, 8));
            clip_h = 16'($urandom_range(0, h + 1));
            capture(w, h, 1'b1, h / 2);
            check_words("rand");
            chk("rand_width", 32'(width), 32'(w));
            chk("rand_height", 32'(height), 32'(h));
            chk("rand_ovf", 32'(overflow), 0);
        end
        ready_rand = 1'b0; ready = 1'b1; hbl = 8;

        // Active-low vs; start during a frame arms for the following frame
        vs_pol = 1'b0; vs = 1'b1; mode = 3'd0; clip_w = 16'd16; clip_h = 16'd16;
        repeat (6) tick();
        vsync_pulse();
        send_lines(6, 4, 1'b0, 1'b0, 8'h80, 2);
        vsync_pulse();
        send_lines(6, 4, 1'b0, 1'b1, 0, -1);
        vs = 1'b0; repeat (5) tick();
        chk("t6_done_on_falling_vs", 32'(done), 1);
        vs = 1'b1; repeat (4) tick();
        check_words("t6");
        chk("t6_width", 32'(width), 6); chk("t6_height", 32'(height), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
